// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit count, scan states, hex glyphs.
// Pure declarations; no latency or backpressure of its own.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  // Segment order a..g maps to bit6..bit0, active-high.
  localparam logic [6:0] SEG7 [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/seven_seg_hex_enc.sv
// Hex nibble to seven-segment glyph encoder; purely combinational, zero latency.
// No handshake, so it never stalls; all 16 codes map to a glyph.
module seven_seg_hex_enc
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG7[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 8-digit multiplexed display scanner; outputs registered (1 cycle), new value shown from next frame boundary.
// in_ready drops while a value is staged; SEVEN_SEG_LZS_EN enables leading-zero suppression.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [6:0]  seg,
  output logic [7:0]  dig_en,
  output logic        frame_done
);

  localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int DW         = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);

  scan_state_t   state, state_nxt;
  logic [DW-1:0] digit, digit_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          boundary;

  logic [31:0]   shadow, pending;
  logic          pending_full;
  logic          accept;

  logic [3:0]    cur_nibble;
  logic [6:0]    cur_pattern;
  logic          lit;
  logic [6:0]    seg_d;
  logic [7:0]    dig_en_d;

  assign in_ready = !pending_full;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SHOW;
      digit        <= '0;
      cnt          <= DWELL_LOAD;
      shadow       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      seg          <= '0;
      dig_en       <= '0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      digit      <= digit_nxt;
      cnt        <= cnt_nxt;
      seg        <= seg_d;
      dig_en     <= dig_en_d;
      frame_done <= boundary;
      // A staged value blocks acceptance, so swap and accept never coincide.
      if (boundary && pending_full) begin
        shadow       <= pending;
        pending_full <= 1'b0;
      end else if (accept) begin
        pending      <= in_data;
        pending_full <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    digit_nxt = digit;
    cnt_nxt   = cnt - 1'b1;
    boundary  = 1'b0;
    if (cnt <= CW'(1)) begin
      unique case (state)
        SHOW: begin
          if (BLANK_CYCLES == 0) begin
            digit_nxt = digit + 1'b1;
            cnt_nxt   = DWELL_LOAD;
            boundary  = (digit == LAST_DIGIT);
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = BLANK_LOAD;
          end
        end
        BLANK: begin
          state_nxt = SHOW;
          digit_nxt = digit + 1'b1;
          cnt_nxt   = DWELL_LOAD;
          boundary  = (digit == LAST_DIGIT);
        end
        default: begin
          state_nxt = SHOW;
          cnt_nxt   = DWELL_LOAD;
        end
      endcase
    end
  end

  assign cur_nibble = shadow[{digit, 2'b00} +: 4];

  seven_seg_hex_enc u_enc (
    .nibble  (cur_nibble),
    .pattern (cur_pattern)
  );

`ifdef SEVEN_SEG_LZS_EN
  logic [DW-1:0] top_digit;

  // Digit 0 stays the floor so an all-zero value still shows one "0".
  always_comb begin
    top_digit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (shadow[4*k +: 4] != 4'h0) top_digit = DW'(k);
    end
  end

  assign lit = (digit <= top_digit);
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    seg_d    = '0;
    dig_en_d = '0;
    if (state == SHOW && lit) begin
      seg_d    = cur_pattern;
      dig_en_d = 8'(1) << digit;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DWELL=4/BLANK=2, plus a BLANK=0 instance for gapless timing.
// Cycle numbers count posedges after reset release; outputs are sampled 1 time unit after each edge.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [6:0]  seg;
  logic [7:0]  dig_en;
  logic        frame_done;

  logic        in_ready0;
  logic [6:0]  seg0;
  logic [7:0]  dig_en0;
  logic        frame_done0;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  seven_seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (1'b0),
    .in_data    (32'h0),
    .in_ready   (in_ready0),
    .seg        (seg0),
    .dig_en     (dig_en0),
    .frame_done (frame_done0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic offer(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_seg", seg, 0);
    check("rst_dig_en", dig_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // First frame timing
    run_to(1);
    check("c1_dig_en", dig_en, 8'h01);
    check("c1_seg", seg, 7'h7E);
    check("c1_dig_en0", dig_en0, 8'h01);
    run_to(4);
    check("c4_dig_en", dig_en, 8'h01);
    run_to(5);
    check("c5_blank_dig_en", dig_en, 8'h00);
    check("c5_blank_seg", seg, 7'h00);
    run_to(7);
    check("c7_dig_en", dig_en, 8'h02);
    check("c7_seg", seg, 7'h7E);
    run_to(9);
    check("c9_dig_en0", dig_en0, 8'h04);
    check("c9_in_ready", in_ready, 1);
    offer(32'h1234ABCD);
    run_to(10);
    check("c10_in_ready_after_accept", in_ready, 0);
    in_valid = 1'b0;

    // Gapless instance stays one-hot; the main display keeps the old value
    while (cyc < 32) begin
      tick();
      check("nogap_onehot", 32'($onehot(dig_en0)), 1);
      if (cyc == 25) begin
        check("c25_old_dig_en", dig_en, 8'h10);
        check("c25_old_seg", seg, 7'h7E);
      end
      if (cyc == 31) check("nogap_fd_early", frame_done0, 0);
    end
    check("nogap_fd_32", frame_done0, 1);
    run_to(33);
    check("nogap_c33_dig_en0", dig_en0, 8'h01);

    // Boundary swaps in 1234ABCD
    run_to(47);
    check("c47_frame_done", frame_done, 0);
    run_to(48);
    check("c48_frame_done", frame_done, 1);
    check("c48_in_ready", in_ready, 1);
    run_to(49);
    check("c49_frame_done", frame_done, 0);
    check("c49_dig_en", dig_en, 8'h01);
    check("c49_seg_d", seg, 7'h3D);
    run_to(55);
    check("c55_seg_c", seg, 7'h4E);
    run_to(61);
    check("c61_seg_b", seg, 7'h1F);
    run_to(67);
    check("c67_seg_a", seg, 7'h77);
    run_to(91);
    check("c91_dig_en", dig_en, 8'h80);
    check("c91_seg_1", seg, 7'h30);
    run_to(96);
    check("c96_frame_done", frame_done, 1);

    // Back-pressure: second value waits for the boundary
    run_to(99);
    offer(32'h11111111);
    run_to(100);
    check("bp_c100_in_ready", in_ready, 0);
    offer(32'h22222222);
    run_to(101);
    check("bp_c101_in_ready", in_ready, 0);
    run_to(144);
    check("bp_c144_frame_done", frame_done, 1);
    check("bp_c144_in_ready", in_ready, 1);
    run_to(145);
    check("bp_c145_in_ready", in_ready, 0);
    in_valid = 1'b0;
    check("bp_c145_dig_en", dig_en, 8'h01);
    check("bp_c145_seg_1", seg, 7'h30);
    run_to(151);
    check("bp_c151_seg_1", seg, 7'h30);
    run_to(192);
    check("bp_c192_frame_done", frame_done, 1);
    run_to(193);
    check("bp_c193_seg_2", seg, 7'h6D);

    // Leading-zero behaviour with A5 then 0
    run_to(199);
    offer(32'h000000A5);
    run_to(200);
    in_valid = 1'b0;
    run_to(241);
    check("a5_d0_dig_en", dig_en, 8'h01);
    check("a5_d0_seg", seg, 7'h5B);
    run_to(247);
    check("a5_d1_dig_en", dig_en, 8'h02);
    check("a5_d1_seg", seg, 7'h77);
    run_to(249);
    offer(32'h00000000);
    run_to(250);
    in_valid = 1'b0;
    run_to(253);
`ifdef SEVEN_SEG_LZS_EN
    check("a5_d2_dig_en", dig_en, 8'h00);
    check("a5_d2_seg", seg, 7'h00);
`else
    check("a5_d2_dig_en", dig_en, 8'h04);
    check("a5_d2_seg", seg, 7'h7E);
`endif
    run_to(289);
    check("z_d0_dig_en", dig_en, 8'h01);
    check("z_d0_seg", seg, 7'h7E);
    run_to(295);
`ifdef SEVEN_SEG_LZS_EN
    check("z_d1_dig_en", dig_en, 8'h00);
    check("z_d1_seg", seg, 7'h00);
`else
    check("z_d1_dig_en", dig_en, 8'h02);
    check("z_d1_seg", seg, 7'h7E);
`endif

    // Mid-frame reset with a value staged
    run_to(299);
    offer(32'h99999999);
    run_to(300);
    in_valid = 1'b0;
    check("mr_pending_full", in_ready, 0);
    run_to(303);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_seg", seg, 0);
    check("mr_async_dig_en", dig_en, 0);
    check("mr_async_dig_en0", dig_en0, 0);
    check("mr_async_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    run_to(1);
    check("mr_c1_dig_en", dig_en, 8'h01);
    check("mr_c1_seg", seg, 7'h7E);
    run_to(48);
    check("mr_c48_frame_done", frame_done, 1);
    run_to(49);
    check("mr_c49_seg", seg, 7'h7E);
    run_to(67);
    check("mr_c67_dig_en", dig_en, 8'h08);
    check("mr_c67_seg", seg, 7'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It accepts 32-bit display values from the core over a valid/ready handshake and double-buffers them. It then drives one shared segment bus plus eight digit enables, one hexadecimal nibble per digit, with a blanking gap between digits to suppress ghosting. New values take effect only at frame boundaries, so a frame never shows a mix of old and new nibbles.

## Interface
- DWELL_CYCLES, 50000: cycles each digit is lit; must be ≥1
- BLANK_CYCLES, 500: dark cycles after each digit; 0 removes the gap
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data offered
- in_data  input  32  value to display; nibble k drives digit k (digit 0 = bits [3:0])
- in_ready  output  1  pending buffer empty; transfer occurs on in_valid & in_ready at posedge
- seg  output  7  segment pattern, bit6=a … bit0=g, active-high
- dig_en  output  8  one-hot digit enable, active-high
- frame_done  output  1  one-cycle pulse at the end of each full 8-digit frame

## Operation
- Registers:
  - shadow[31:0]: the value currently displayed
  - pending[31:0] with pending_full flag: the staged next value
  - state: SHOW or BLANK
  - digit index: 0..7
  - cycle counter
- in_ready = !pending_full, driven combinationally from the flag.
- An accepted transfer loads pending and sets pending_full.
- SHOW:
  - dig_en = 1<<digit; seg = hex pattern of shadow nibble [digit].
  - After DWELL_CYCLES, go to BLANK. If BLANK_CYCLES=0, skip BLANK and advance directly.
- BLANK:
  - dig_en = 0, seg = 0.
  - After BLANK_CYCLES, digit increments and the next SHOW starts.
- Frame boundary = leaving the last slot of digit 7. On that cycle:
  - digit wraps to 0;
  - frame_done pulses;
  - if pending_full, shadow ← pending and pending_full clears.
- Accept on the boundary cycle: pending_full was 0, so there is nothing to transfer. The new value is held in pending and displayed from the following boundary, one frame later.
- Hex map:
  - 0:7E, 1:30, 2:6D, 3:79, 4:33, 5:5B, 6:5F, 7:70
  - 8:7F, 9:7B, A:77, b:1F, C:4E, d:3D, E:4F, F:47
- Counter width = $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). The counter counts down and reloads on each state change.

## Timing
- Reset values while rst_n=0:
  - seg=0, dig_en=0, frame_done=0
  - shadow=0, pending_full=0, so in_ready=1
  - state=SHOW, digit=0, counter loaded with DWELL_CYCLES
- seg, dig_en and frame_done are registered.
- First posedge after rst_n rises: dig_en=8'h01, seg=7'h7E.
- Frame period = 8·(DWELL_CYCLES+BLANK_CYCLES) cycles.
- Input-to-display latency: at most 2 frames, at least 1 cycle after the accepting edge.
- Reset mid-frame:
  - outputs go dark immediately (asynchronous);
  - a pending value is discarded;
  - scanning restarts at digit 0 showing 0.

## Configuration
- SEVEN_SEG_LZS_EN defined: leading-zero suppression.
  - Digits above the highest non-zero shadow nibble keep dig_en=0 and seg=0 during their SHOW slot.
  - Slot timing and frame period are unchanged.
  - Digit 0 is always lit, so value 0 shows a single "0".
- Undefined: all eight digits are always lit.

## Structure
- Package seven_seg_pkg contains:
  - NUM_DIGITS=8
  - scan-state enum {SHOW, BLANK}
  - the 16-entry SEG7 hex constants
- One sub-module, seven_seg_hex_enc: combinational, 4-bit nibble → 7-bit pattern, fully specified for all 16 inputs.
- The controller instantiates one encoder and drives it from a nibble mux on digit.

## Test plan
All scenarios use DWELL_CYCLES=4, BLANK_CYCLES=2.
- Reset release → seg=0 and dig_en=0 during reset; cycle 1: dig_en=01, seg=7E; digit 1 lit from cycle 7; frame_done every 48 cycles.
- Accept 32'h1234ABCD at cycle 10 → digits unchanged until frame_done. Next frame shows:
  - digit0 = 3D, digit1 = 4E, digit2 = 1F, digit3 = 77
  - digit7 = 30
- Back-pressure: offer 32'h11111111, then 32'h22222222 in the same frame → in_ready=0 after the first accept. The second value is accepted on the cycle after the boundary and shown one frame later.
- BLANK_CYCLES=0 build → no dark gaps, dig_en one-hot every cycle, frame = 32 cycles.
- SEVEN_SEG_LZS_EN with shadow 32'h000000A5 → only digit0 (5B) and digit1 (77) lit. With 32'h0 → only digit0 lit, showing 7E.
- Assert rst_n low mid-frame with pending_full=1 → outputs 0 immediately. After release, digit0 shows 7E and the pending value is never displayed.
